router_sync_n: RTL and testbench
================================

ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NCH, default 3, number of output channels (legal 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 30, stall cycles before soft reset (legal 2..1023).
REQ-003 SHALL derive localparam AW = max(1, clog2(NCH)) and CW = clog2(TIMEOUT+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port detect_add  input  1  header-byte strobe; capture datain as destination.
REQ-007 SHALL have port datain  input  AW  destination channel address.
REQ-008 SHALL have port write_enb_reg  input  1  FSM write request for the current packet.
REQ-009 SHALL have port read_enb  input  NCH  per-channel FIFO read strobe from the downstream reader.
REQ-010 SHALL have port empty  input  NCH  per-channel FIFO empty flag.
REQ-011 SHALL have port full  input  NCH  per-channel FIFO full flag.
REQ-012 SHALL have port sts_clr  input  1  clears sticky timeout status.
REQ-013 SHALL have port vld_out  output  NCH  per-channel data-valid to the reader.
REQ-014 SHALL have port write_enb  output  NCH  one-hot FIFO write enable.
REQ-015 SHALL have port fifo_full  output  1  full flag of the selected channel.
REQ-016 SHALL have port soft_reset  output  NCH  per-channel one-cycle FIFO flush pulse.
REQ-017 SHALL have port addr_err  output  1  one-cycle pulse on capture of an out-of-range address.
REQ-018 SHALL have port timeout_sts  output  NCH  sticky per-channel timeout record.

Function
REQ-019 SHALL drive vld_out[i] = ~empty[i] combinationally.
REQ-020 SHALL, on a clock edge with detect_add=1, load sel <= datain and sel_vld <= (datain < NCH); the new sel takes effect from the following cycle.
REQ-021 SHALL pulse addr_err high for exactly the cycle after a capture with datain >= NCH; otherwise addr_err = 0.
REQ-022 SHALL drive write_enb combinationally = one-hot(sel) when write_enb_reg=1 and sel_vld=1, else all zeros; never X/Z, never more than one bit set.
REQ-023 SHALL drive fifo_full combinationally = full[sel] when sel_vld=1, else 0.
REQ-024 SHALL keep per-channel counter cnt[i] (CW bits): increment when vld_out[i]=1 and read_enb[i]=0; load 0 when read_enb[i]=1 or vld_out[i]=0.
REQ-025 SHALL, on an edge where cnt[i]=TIMEOUT-1, vld_out[i]=1 and read_enb[i]=0, set soft_reset[i] <= 1 and cnt[i] <= 0; soft_reset[i] = 0 on every other edge (one-cycle pulse, first pulse at the TIMEOUT-th consecutive stalled edge).
REQ-026 SHALL suppress the pulse if read_enb[i]=1 in the would-be timeout cycle (read wins); counting restarts from 0.
REQ-027 SHALL, if the stall persists after a pulse, count afresh and pulse again TIMEOUT edges later; counters never wrap or saturate beyond TIMEOUT-1.
REQ-028 SHALL operate all NCH channels independently; simultaneous timeouts on several channels pulse together.

Reset
REQ-029 SHALL, while resetn=0, asynchronously force sel=0, sel_vld=0, cnt=0, soft_reset=0, addr_err=0, timeout_sts=0; combinational outputs follow from these and from the inputs.
REQ-030 SHALL, on reset asserted mid-stall, discard partial counts; counting restarts from 0 after release.

Configuration
REQ-031 SHALL, with macro ROUTER_SYNC_N_STICKY_STS_EN defined, set timeout_sts[i] on each soft_reset[i] pulse and hold it until sts_clr=1 (set wins over clear in the same cycle).
REQ-032 SHALL, without ROUTER_SYNC_N_STICKY_STS_EN, tie timeout_sts to 0 and ignore sts_clr; the port list is identical in both builds.

Verification
REQ-033 SHALL cover: NCH=3, detect_add with datain=2, write_enb_reg=1 next cycle -> write_enb=3'b100, fifo_full mirrors full[2].
REQ-034 SHALL cover: NCH=3, datain=3 captured -> addr_err pulses one cycle, write_enb=0, fifo_full=0 with write_enb_reg=1.
REQ-035 SHALL cover: TIMEOUT=30, empty[0]=0, read_enb[0]=0 held -> soft_reset[0] high for one cycle at the 30th edge, again at the 60th.
REQ-036 SHALL cover: stall 29 cycles then read_enb[1]=1 on cycle 30 -> no soft_reset[1]; cnt[1]=0.
REQ-037 SHALL cover: resetn dropped asynchronously at stall cycle 15 on channel 2 -> outputs clear immediately; after release, pulse only after 30 further stalled edges.
REQ-038 SHALL cover: with ROUTER_SYNC_N_STICKY_STS_EN, timeout on channel 0 -> timeout_sts=3'b001 until sts_clr; without the macro -> timeout_sts stays 0.

Source files
------------

// File: rtl/router_sync_n.sv
// router_sync_n: destination latch, one-hot FIFO write select and per-channel stall watchdog (1-cycle capture, combinational enables).
// Build option ROUTER_SYNC_N_STICKY_STS_EN keeps a sticky per-channel timeout record in timeout_sts, cleared by sts_clr.
module router_sync_n #(
   parameter int NCH     = 3,
   parameter int TIMEOUT = 30,
   localparam int AW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           detect_add,
   input  logic [AW-1:0]  datain,
   input  logic           write_enb_reg,
   input  logic [NCH-1:0] read_enb,
   input  logic [NCH-1:0] empty,
   input  logic [NCH-1:0] full,
   input  logic           sts_clr,
   output logic [NCH-1:0] vld_out,
   output logic [NCH-1:0] write_enb,
   output logic           fifo_full,
   output logic [NCH-1:0] soft_reset,
   output logic           addr_err,
   output logic [NCH-1:0] timeout_sts
);

   localparam logic [AW:0] NCH_W = (AW+1)'(NCH);

   logic [AW-1:0]          sel_q;
   logic                   sel_vld_q;
   logic                   addr_err_q;
   logic                   in_range;
   logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]         soft_reset_q, soft_reset_d;

   assign vld_out    = ~empty;
   assign in_range   = ({1'b0, datain} < NCH_W);
   assign addr_err   = addr_err_q;
   assign soft_reset = soft_reset_q;

   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (sel_vld_q && (sel_q == AW'(i))) begin
            write_enb[i] = write_enb_reg;
            fifo_full    = full[i];
         end
      end
   end

   // A read or an empty FIFO restarts the count; the wrap edge produces the pulse.
   always_comb begin
      cnt_d        = '0;
      soft_reset_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (vld_out[i] && !read_enb[i]) begin
            if (cnt_q[i] == CW'(TIMEOUT - 1)) begin
               soft_reset_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_q        <= '0;
         sel_vld_q    <= 1'b0;
         addr_err_q   <= 1'b0;
         cnt_q        <= '0;
         soft_reset_q <= '0;
      end else begin
         if (detect_add) begin
            sel_q     <= datain;
            sel_vld_q <= in_range;
         end
         addr_err_q   <= detect_add && !in_range;
         cnt_q        <= cnt_d;
         soft_reset_q <= soft_reset_d;
      end
   end

`ifdef ROUTER_SYNC_N_STICKY_STS_EN
   logic [NCH-1:0] sts_q, sts_d;

   // Set is taken from the pulse being launched, so it wins over a same-cycle clear.
   assign sts_d = (sts_q & ~{NCH{sts_clr}}) | soft_reset_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sts_q <= '0;
      end else begin
         sts_q <= sts_d;
      end
   end

   assign timeout_sts = sts_q;
`else
   logic unused_sts_clr;
   assign unused_sts_clr = sts_clr;
   assign timeout_sts    = '0;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Testbench for router_sync_n with NCH=3, TIMEOUT=30; expected values flow through a scoreboard queue.
module tb_router_sync_n;
   localparam int NCH     = 3;
   localparam int TIMEOUT = 30;
   localparam int AW      = 2;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           detect_add = 1'b0;
   logic [AW-1:0]  datain = '0;
   logic           write_enb_reg = 1'b0;
   logic [NCH-1:0] read_enb = '0;
   logic [NCH-1:0] empty = '1;
   logic [NCH-1:0] full = '0;
   logic           sts_clr = 1'b0;
   logic [NCH-1:0] vld_out, write_enb, soft_reset, timeout_sts;
   logic           fifo_full, addr_err;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp;
   logic [7:0] exp_sts;

   router_sync_n #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .detect_add(detect_add), .datain(datain),
      .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
      .sts_clr(sts_clr), .vld_out(vld_out), .write_enb(write_enb), .fifo_full(fifo_full),
      .soft_reset(soft_reset), .addr_err(addr_err), .timeout_sts(timeout_sts)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      write_enb_reg = 1'b1;
      full = '1;
      empty = 3'b101;
      #12;
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL reset_write_enb: got %h want %h", write_enb, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(fifo_full) !== exp) begin errors++; $display("FAIL reset_fifo_full: got %h want %h", fifo_full, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(soft_reset) !== exp) begin errors++; $display("FAIL reset_soft_reset: got %h want %h", soft_reset, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(addr_err) !== exp) begin errors++; $display("FAIL reset_addr_err: got %h want %h", addr_err, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(timeout_sts) !== exp) begin errors++; $display("FAIL reset_timeout_sts: got %h want %h", timeout_sts, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(vld_out) !== exp) begin errors++; $display("FAIL reset_vld_out: got %h want %h", vld_out, exp); end
      write_enb_reg = 1'b0;
      full = '0;
      empty = '1;
      step();
      resetn = 1'b1;
   endtask

   task automatic test_route();
      detect_add = 1'b1;
      datain = 2'd2;
      step();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      full = 3'b100;
      exp_q.push_back(8'h04); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL route_write_enb: got %h want %h", write_enb, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(fifo_full) !== exp) begin errors++; $display("FAIL route_fifo_full_set: got %h want %h", fifo_full, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(addr_err) !== exp) begin errors++; $display("FAIL route_addr_err: got %h want %h", addr_err, exp); end
      full = 3'b011;
      exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(fifo_full) !== exp) begin errors++; $display("FAIL route_fifo_full_clr: got %h want %h", fifo_full, exp); end
      write_enb_reg = 1'b0;
      exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL route_write_enb_idle: got %h want %h", write_enb, exp); end
      empty = 3'b010;
      exp_q.push_back(8'h05);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(vld_out) !== exp) begin errors++; $display("FAIL route_vld_out: got %h want %h", vld_out, exp); end
      empty = '1;
      full = '0;
   endtask

   task automatic test_addr_err();
      detect_add = 1'b1;
      datain = 2'd3;
      step();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      full = '1;
      exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(addr_err) !== exp) begin errors++; $display("FAIL adr_err_pulse: got %h want %h", addr_err, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL adr_err_write_enb: got %h want %h", write_enb, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(fifo_full) !== exp) begin errors++; $display("FAIL adr_err_fifo_full: got %h want %h", fifo_full, exp); end
      exp_q.push_back(8'h00);
      step();
      exp = exp_q.pop_front(); checks++;
      if (8'(addr_err) !== exp) begin errors++; $display("FAIL adr_err_one_cycle: got %h want %h", addr_err, exp); end
      detect_add = 1'b1;
      datain = 2'd0;
      step();
      detect_add = 1'b0;
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(addr_err) !== exp) begin errors++; $display("FAIL adr_ok_no_err: got %h want %h", addr_err, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL adr_ok_write_enb: got %h want %h", write_enb, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(fifo_full) !== exp) begin errors++; $display("FAIL adr_ok_fifo_full: got %h want %h", fifo_full, exp); end
      write_enb_reg = 1'b0;
      full = '0;
   endtask

   task automatic test_timeout();
      empty = 3'b110;
      read_enb = '0;
      for (int k = 1; k <= 2 * TIMEOUT; k++) begin
         exp_q.push_back((k == TIMEOUT || k == 2 * TIMEOUT) ? 8'h01 : 8'h00);
         step();
         exp = exp_q.pop_front(); checks++;
         if (8'(soft_reset) !== exp) begin errors++; $display("FAIL timeout_edge%0d: got %h want %h", k, soft_reset, exp); end
      end
      empty = '1;
`ifdef ROUTER_SYNC_N_STICKY_STS_EN
      exp_sts = 8'h01;
`else
      exp_sts = 8'h00;
`endif
      exp_q.push_back(exp_sts);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(timeout_sts) !== exp) begin errors++; $display("FAIL sticky_set: got %h want %h", timeout_sts, exp); end
      sts_clr = 1'b1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      step();
      sts_clr = 1'b0;
      exp = exp_q.pop_front(); checks++;
      if (8'(timeout_sts) !== exp) begin errors++; $display("FAIL sticky_clr: got %h want %h", timeout_sts, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(soft_reset) !== exp) begin errors++; $display("FAIL timeout_idle: got %h want %h", soft_reset, exp); end
   endtask

   task automatic test_read_wins();
      empty = 3'b101;
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == TIMEOUT) read_enb = 3'b010;
         exp_q.push_back(8'h00);
         step();
         exp = exp_q.pop_front(); checks++;
         if (8'(soft_reset) !== exp) begin errors++; $display("FAIL read_wins_edge%0d: got %h want %h", k, soft_reset, exp); end
      end
      read_enb = '0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         exp_q.push_back((k == TIMEOUT) ? 8'h02 : 8'h00);
         step();
         exp = exp_q.pop_front(); checks++;
         if (8'(soft_reset) !== exp) begin errors++; $display("FAIL read_restart_edge%0d: got %h want %h", k, soft_reset, exp); end
      end
      empty = '1;
   endtask

   task automatic test_reset_mid();
      detect_add = 1'b1;
      datain = 2'd2;
      step();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      empty = 3'b011;
      for (int k = 1; k <= 15; k++) step();
      exp_q.push_back(8'h04);
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL mid_pre_write_enb: got %h want %h", write_enb, exp); end
      #3;
      resetn = 1'b0;
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (8'(write_enb) !== exp) begin errors++; $display("FAIL mid_rst_write_enb: got %h want %h", write_enb, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(soft_reset) !== exp) begin errors++; $display("FAIL mid_rst_soft_reset: got %h want %h", soft_reset, exp); end
      exp = exp_q.pop_front(); checks++;
      if (8'(timeout_sts) !== exp) begin errors++; $display("FAIL mid_rst_timeout_sts: got %h want %h", timeout_sts, exp); end
      step();
      step();
      resetn = 1'b1;
      for (int k = 1; k <= TIMEOUT; k++) begin
         exp_q.push_back((k == TIMEOUT) ? 8'h04 : 8'h00);
         step();
         exp = exp_q.pop_front(); checks++;
         if (8'(soft_reset) !== exp) begin errors++; $display("FAIL mid_restart_edge%0d: got %h want %h", k, soft_reset, exp); end
      end
      empty = '1;
      write_enb_reg = 1'b0;
   endtask

   task automatic test_back_to_back();
      step();
      empty = 3'b100;
      for (int k = 1; k <= TIMEOUT; k++) begin
         exp_q.push_back((k == TIMEOUT) ? 8'h03 : 8'h00);
         step();
         exp = exp_q.pop_front(); checks++;
         if (8'(soft_reset) !== exp) begin errors++; $display("FAIL multi_edge%0d: got %h want %h", k, soft_reset, exp); end
      end
      empty = '1;
      exp_q.push_back(8'h00);
      step();
      exp = exp_q.pop_front(); checks++;
      if (8'(soft_reset) !== exp) begin errors++; $display("FAIL multi_after: got %h want %h", soft_reset, exp); end
   endtask

   initial begin
      test_reset();
      test_route();
      test_addr_err();
      test_timeout();
      test_read_wins();
      test_reset_mid();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
